// File: rtl/cnn_pkg.sv
// Shared CNN pipeline types and sizing helpers used by the layer blocks.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package cnn_pkg;

  // Layer control states shared by the layer blocks
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Output edge of a non-overlapping pool/stride; remainder rows/cols drop out
  function automatic int out_dim(input int in_dim, input int pool);
    return in_dim / pool;
  endfunction

  // Bits needed to count 0..n-1, never less than one bit
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/maxpool_layer_window_max_acc.sv
// Running unsigned max over one pooling window; o_res carries the window max.
// Latency: combinational result in the cycle of the last element.
// Backpressure: none; one element accepted per i_en cycle.
module window_max_acc #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clr,
  input  logic                  i_en,
  input  logic                  i_first,
  input  logic                  i_last,
  input  logic [DATA_WIDTH-1:0] i_dat,
  output logic [DATA_WIDTH-1:0] o_res,
  output logic                  o_res_vld
);

  logic [DATA_WIDTH-1:0] r_max;
  logic [DATA_WIDTH-1:0] w_max;

  // First element seeds the window; later ones keep the larger unsigned value
  always_comb begin
    w_max = r_max;
    if (i_first) begin
      w_max = i_dat;
    end else if (i_dat > r_max) begin
      w_max = i_dat;
    end
  end

  assign o_res     = w_max;
  assign o_res_vld = i_en & i_last;

  // Hold the running max between elements of the current window
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_max <= '0;
    end else if (i_clr) begin
      r_max <= '0;
    end else if (i_en) begin
      r_max <= w_max;
    end
  end

endmodule

// File: rtl/maxpool_layer.sv
// Non-overlapping max pool: latch input map on start edge, scan one element per cycle.
// Latency: layer_done_out rises OUTROW*OUTCOL*POOL_SIZE^2 cycles after the start edge.
// Backpressure: none; start_in level handshake, must drop low before a new pass.
module maxpool_layer
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int INROW      = 24,
  parameter int INCOL      = 24,
  parameter int POOL_SIZE  = 2,
  localparam int OUTROW    = out_dim(INROW, POOL_SIZE),
  localparam int OUTCOL    = out_dim(INCOL, POOL_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_in,
  input  logic [DATA_WIDTH-1:0] feat_in  [0:INROW-1][0:INCOL-1],
  output logic [DATA_WIDTH-1:0] pool_out [0:OUTROW-1][0:OUTCOL-1],
  output logic                  layer_done_out
);

  localparam int WR_W = cnt_w(OUTROW);
  localparam int WC_W = cnt_w(OUTCOL);
  localparam int P_W  = cnt_w(POOL_SIZE);
  localparam int R_W  = cnt_w(INROW);
  localparam int C_W  = cnt_w(INCOL);

  localparam logic [WR_W-1:0] WR_LAST = WR_W'(OUTROW - 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(OUTCOL - 1);
  localparam logic [P_W-1:0]  P_LAST  = P_W'(POOL_SIZE - 1);

  state_t r_state;
  state_t w_next;

  logic                  r_start_q;
  logic [DATA_WIDTH-1:0] r_buf  [0:INROW-1][0:INCOL-1];
  logic [DATA_WIDTH-1:0] r_pool [0:OUTROW-1][0:OUTCOL-1];
  logic [WR_W-1:0]       r_wr;
  logic [WC_W-1:0]       r_wc;
  logic [P_W-1:0]        r_pr;
  logic [P_W-1:0]        r_pc;

  logic                  w_start;
  logic                  w_scan;
  logic                  w_first;
  logic                  w_win_last;
  logic                  w_scan_last;
  logic [R_W-1:0]        w_row;
  logic [C_W-1:0]        w_col;
  logic [DATA_WIDTH-1:0] w_elem;
  logic [DATA_WIDTH-1:0] w_res;
  logic                  w_res_vld;

  // Rising start is only honoured while idle; mid-scan toggles are ignored
  assign w_start     = (r_state == IDLE) && start_in && !r_start_q;
  assign w_first     = (r_pr == '0) && (r_pc == '0);
  assign w_win_last  = (r_pr == P_LAST) && (r_pc == P_LAST);
  assign w_scan_last = w_win_last && (r_wr == WR_LAST) && (r_wc == WC_LAST);
  assign w_row       = R_W'(int'(r_wr) * POOL_SIZE + int'(r_pr));
  assign w_col       = C_W'(int'(r_wc) * POOL_SIZE + int'(r_pc));
  assign w_elem      = r_buf[w_row][w_col];
  assign pool_out    = r_pool;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: start edge -> scan -> done, leave done once start drops
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start)     w_next = SCAN;
      SCAN:    if (w_scan_last) w_next = DONE;
      DONE:    if (!start_in)   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs decoded from the registered state
  always_comb begin
    w_scan         = 1'b0;
    layer_done_out = 1'b0;
    case (r_state)
      SCAN:    w_scan         = 1'b1;
      DONE:    layer_done_out = 1'b1;
      default: ;
    endcase
  end

  // Previous start_in sample for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_start_q <= 1'b0;
    end else begin
      r_start_q <= start_in;
    end
  end

  // Snapshot the input map so later feat_in changes cannot disturb the pass
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < INROW; i++)
        for (int j = 0; j < INCOL; j++)
          r_buf[i][j] <= '0;
    end else if (w_start) begin
      r_buf <= feat_in;
    end
  end

  // Window-major scan: column, row inside window, then window column, window row
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr <= '0;
      r_wc <= '0;
      r_pr <= '0;
      r_pc <= '0;
    end else if (w_start) begin
      r_wr <= '0;
      r_wc <= '0;
      r_pr <= '0;
      r_pc <= '0;
    end else if (w_scan) begin
      if (r_pc != P_LAST) begin
        r_pc <= r_pc + P_W'(1);
      end else begin
        r_pc <= '0;
        if (r_pr != P_LAST) begin
          r_pr <= r_pr + P_W'(1);
        end else begin
          r_pr <= '0;
          if (r_wc != WC_LAST) begin
            r_wc <= r_wc + WC_W'(1);
          end else begin
            r_wc <= '0;
            if (r_wr != WR_LAST) r_wr <= r_wr + WR_W'(1);
          end
        end
      end
    end
  end

  window_max_acc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_acc (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_start),
    .i_en      (w_scan),
    .i_first   (w_first),
    .i_last    (w_win_last),
    .i_dat     (w_elem),
    .o_res     (w_res),
    .o_res_vld (w_res_vld)
  );

  // Write each window max as its last element is consumed; old entries persist
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < OUTROW; i++)
        for (int j = 0; j < OUTCOL; j++)
          r_pool[i][j] <= '0;
    end else if (w_res_vld) begin
      r_pool[r_wr][r_wc] <= w_res;
    end
  end

endmodule

// File: tb/tb_maxpool_layer.sv
module tb_maxpool_layer;

  logic       clk = 1'b0;
  logic       rst4, rst24, start4, start24;
  logic [7:0] feat4  [0:3][0:3];
  logic [7:0] pool4  [0:1][0:1];
  logic       done4;
  logic [7:0] feat24 [0:23][0:23];
  logic [7:0] pool24 [0:11][0:11];
  logic       done24;

  int cyc   = 0;
  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp4_q[$];
  int         cyc4_q[$];
  logic [7:0] exp24_q[$];
  int         cyc24_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  maxpool_layer #(.DATA_WIDTH(8), .INROW(4), .INCOL(4), .POOL_SIZE(2)) u_dut4 (
    .clk(clk), .rst(rst4), .start_in(start4), .feat_in(feat4),
    .pool_out(pool4), .layer_done_out(done4)
  );

  maxpool_layer #(.DATA_WIDTH(8), .INROW(24), .INCOL(24), .POOL_SIZE(2)) u_dut24 (
    .clk(clk), .rst(rst24), .start_in(start24), .feat_in(feat24),
    .pool_out(pool24), .layer_done_out(done24)
  );

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pop expectations whenever a DUT raises layer_done_out
  initial begin
    logic d4_prev, d24_prev;
    int   e;
    logic [7:0] ev;
    d4_prev  = 1'b0;
    d24_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done4 && !d4_prev) begin
        if (cyc4_q.size() == 0) begin
          check("dut4 done with no pass pending", cyc, -1);
        end else begin
          e = cyc4_q.pop_front();
          check("dut4 done edge", cyc, e);
          for (int i = 0; i < 4; i++) begin
            ev = exp4_q.pop_front();
            check($sformatf("dut4 pool[%0d][%0d]", i / 2, i % 2), pool4[i/2][i%2], ev);
          end
        end
      end
      if (done24 && !d24_prev) begin
        if (cyc24_q.size() == 0) begin
          check("dut24 done with no pass pending", cyc, -1);
        end else begin
          e = cyc24_q.pop_front();
          check("dut24 done edge", cyc, e);
          for (int i = 0; i < 144; i++) begin
            ev = exp24_q.pop_front();
            check($sformatf("dut24 pool[%0d][%0d]", i / 12, i % 12), pool24[i/12][i%12], ev);
          end
        end
      end
      d4_prev  = done4;
      d24_prev = done24;
    end
  end

  task automatic fill4_lin(input int mult);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        feat4[r][c] = 8'((4 * r + c) * mult);
  endtask

  task automatic fill4_rev(input int mult);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        feat4[r][c] = 8'((15 - (4 * r + c)) * mult);
  endtask

  task automatic set_win4(input int wr, input int wc, input logic [7:0] a, b, c, d);
    feat4[2*wr][2*wc]     = a;
    feat4[2*wr][2*wc+1]   = b;
    feat4[2*wr+1][2*wc]   = c;
    feat4[2*wr+1][2*wc+1] = d;
  endtask

  task automatic push4(input logic [7:0] a, b, c, d, input int done_at);
    exp4_q.push_back(a);
    exp4_q.push_back(b);
    exp4_q.push_back(c);
    exp4_q.push_back(d);
    cyc4_q.push_back(done_at);
  endtask

  // Raise start at a falling edge; n is the rising edge that samples it
  task automatic start_pass4(output int n);
    @(negedge clk);
    start4 = 1'b1;
    @(posedge clk);
    #1 n = cyc;
  endtask

  task automatic wait_done4(input string name);
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done4) break;
    end
    if (k == 100) check({name, " done timeout"}, int'(done4), 1);
  endtask

  task automatic drop_start4_check(input string name);
    @(negedge clk);
    start4 = 1'b0;
    @(posedge clk);
    #1 check({name, " done falls"}, int'(done4), 0);
  endtask

  task automatic check_zero4(input string name);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        check($sformatf("%s pool[%0d][%0d]", name, r, c), pool4[r][c], 0);
    check({name, " done"}, int'(done4), 0);
  endtask

  initial begin
    int n;
    int k;
    logic [7:0] m;
    rst4 = 1'b0; rst24 = 1'b0; start4 = 1'b0; start24 = 1'b0;
    fill4_lin(1);
    for (int r = 0; r < 24; r++)
      for (int c = 0; c < 24; c++)
        feat24[r][c] = 8'((r * 37 + c * 11 + r * c * 5) ^ (r << 3));
    repeat (3) @(negedge clk);

    // Reset state
    check_zero4("reset");
    check("reset dut24 done", int'(done24), 0);
    check("reset dut24 pool[11][11]", pool24[11][11], 0);
    @(negedge clk);
    rst4 = 1'b1; rst24 = 1'b1;
    repeat (2) @(negedge clk);

    // Ramp 0..15
    fill4_lin(1);
    start_pass4(n);
    push4(8'd5, 8'd7, 8'd13, 8'd15, n + 16);
    wait_done4("ramp");
    drop_start4_check("ramp");

    // Ties and extremes
    set_win4(0, 0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    set_win4(0, 1, 8'h00, 8'h00, 8'h00, 8'h00);
    set_win4(1, 0, 8'd3, 8'd3, 8'd3, 8'd2);
    set_win4(1, 1, 8'h80, 8'h7F, 8'h01, 8'h81);
    start_pass4(n);
    push4(8'hFF, 8'h00, 8'd3, 8'h81, n + 16);
    wait_done4("ties");
    drop_start4_check("ties");

    // Reset mid-pass after edge N+7, then a fresh pass
    fill4_rev(1);
    start_pass4(n);
    repeat (7) @(posedge clk);
    #1 rst4 = 1'b0;
    #1 check_zero4("abort");
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    rst4 = 1'b1;
    start_pass4(n);
    push4(8'd15, 8'd13, 8'd7, 8'd5, n + 16);
    wait_done4("after abort");
    drop_start4_check("after abort");

    // Disturbances during scan: feat_in trashed before N+1, start toggled
    fill4_lin(16);
    start_pass4(n);
    push4(8'd80, 8'd112, 8'd208, 8'd240, n + 16);
    @(negedge clk);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        feat4[r][c] = 8'hFF;
    start4 = 1'b0;
    @(negedge clk) start4 = 1'b1;
    @(negedge clk) start4 = 1'b0;
    @(negedge clk) start4 = 1'b1;
    wait_done4("disturb");

    // Restart from DONE with a new map
    drop_start4_check("restart");
    fill4_rev(17);
    start_pass4(n);
    push4(8'd255, 8'd221, 8'd119, 8'd85, n + 16);
    wait_done4("restart");
    drop_start4_check("restart second");

    // Full-size 24x24 map against a straightforward window-max reference
    for (int wr = 0; wr < 12; wr++)
      for (int wc = 0; wc < 12; wc++) begin
        m = 8'd0;
        for (int r = 0; r < 2; r++)
          for (int c = 0; c < 2; c++)
            if (feat24[2*wr+r][2*wc+c] > m) m = feat24[2*wr+r][2*wc+c];
        exp24_q.push_back(m);
      end
    @(negedge clk);
    start24 = 1'b1;
    @(posedge clk);
    #1 n = cyc;
    cyc24_q.push_back(n + 576);
    for (k = 0; k < 700; k++) begin
      @(negedge clk);
      if (done24) break;
    end
    if (k == 700) check("dut24 done timeout", int'(done24), 1);
    @(negedge clk) start24 = 1'b0;

    repeat (3) @(negedge clk);
    check("dut4 passes outstanding", cyc4_q.size(), 0);
    check("dut24 passes outstanding", cyc24_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/maxpool_layer.md
Name: maxpool_layer

Overview:
- Downstream neighbour of conv_layer: consumes the conv_out feature map and conv layer_done_out, and produces a max-pooled map plus its own layer_done_out for the next stage.
- Latches the full input map on start, then scans one input element per cycle, computing each POOL_SIZE x POOL_SIZE window max with stride POOL_SIZE.
- Non-overlapping pooling only; 24x24 -> 12x12 for the MNIST flow.

Parameters:
- DATA_WIDTH, 8, bit width of input and output elements (unsigned; input is post-ReLU).
- INROW, 24, input map rows (IMGROW-KERNEL_SIZE+1 of the conv stage).
- INCOL, 24, input map columns.
- POOL_SIZE, 2, window edge and stride; legal range 1..min(INROW,INCOL).

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- start_in  in  1  level; connect to conv layer_done_out; a 0->1 transition starts a pass.
- feat_in  in  DATA_WIDTH x [0:INROW-1][0:INCOL-1]  input feature map, sampled only on the start edge.
- pool_out  out  DATA_WIDTH x [0:OUTROW-1][0:OUTCOL-1]  pooled map (OUTROW=INROW/POOL_SIZE, OUTCOL=INCOL/POOL_SIZE, integer division).
- layer_done_out  out  1  high while pool_out holds a complete result.

Behaviour:
- Reset (rst=0, async): state IDLE; pool_out all 0; layer_done_out 0; internal buffer, counters and running max 0. A reset mid-pass aborts the pass immediately, with no partial completion.
- Start edge: detected on a registered start_in (prev=0, cur=1) sampled at clock edge N, in IDLE only. At edge N, copy feat_in into the internal buffer, clear the window, row and column counters, and move to SCAN.
- SCAN, one element per cycle:
  - Order: window-major, windows in row-major order (wr, wc); inside a window, row-major (r, c).
  - First element of a window: running max := element.
  - Other elements: running max := max(running, element), unsigned compare; on ties keep either, since the values are equal.
  - Last element of a window: pool_out[wr][wc] := max(running, element), written at that edge.
- Timing:
  - Total scan = OUTROW*OUTCOL*POOL_SIZE^2 cycles; the last window is written at edge N+T, T = that count (576 for defaults).
  - At the same edge N+T, state moves to DONE and layer_done_out goes 1 (registered).
- DONE: pool_out is stable and layer_done_out=1. When start_in is sampled 0, go to IDLE; layer_done_out falls at that edge and pool_out is retained.
- Restarting requires start_in low, then high.
- Ignored inputs:
  - start_in held high or re-toggled during SCAN is ignored; the pass is not restarted.
  - feat_in changes after edge N have no effect.
- Remainder rows/columns (INROW or INCOL not a multiple of POOL_SIZE) are never read.
- POOL_SIZE=1: pool_out equals feat_in after INROW*INCOL cycles.
- pool_out entries not yet rewritten in a new pass keep their old values; only layer_done_out qualifies validity.
- Widths:
  - Counters are sized $clog2 of their range, minimum 1 bit.
  - No arithmetic growth; output width = DATA_WIDTH.

Decomposition:
- Shared package cnn_pkg:
  - state enum (IDLE, SCAN, DONE);
  - constant functions out_dim(in, pool) and cnt_w(n), reusable by conv_layer and later FC stages.
- One sub-module, window_max_acc: DATA_WIDTH register with first/last flags, running-max compare and result strobe.
- The top level keeps the FSM, counters, buffer and output array.

Test Plan:
- Params INROW=INCOL=4, POOL_SIZE=2, feat_in[r][c]=4r+c (0..15), start edge at N -> pool_out={{5,7},{13,15}}; layer_done_out rises at exactly N+16.
- Defaults, MNIST conv output file (24x24) -> pool_out matches the software 2x2 max reference for all 144 entries; done at N+576.
- Ties and extremes: a 4x4 map with a window of all 8'hFF, a window of all 0, and a window {3,3,3,2} -> outputs 255, 0, 3 with no wrap or sign error.
- rst driven low at N+7 mid-pass, then released -> all outputs 0 asynchronously and state IDLE. The next start edge produces a fresh full result with no leftover running max.
- start_in pulsed low/high during SCAN, and feat_in changed at N+1 -> result identical to the undisturbed run; done at N+T unchanged.
- Restart: in DONE drop start_in -> layer_done_out falls next edge; raise it with a new map -> second result correct, done at N2+T.
